// File: rtl/ads1115_i2c_engine.sv
// Bit-level I2C master for the ADS1115 descriptor walker: executes one descriptor
// block per transaction and returns 16-bit register reads. SCL is push-pull.
module ads1115_i2c_engine #(
  parameter int CLK_DIV      = 125,
  parameter int DELAY_CYCLES = 1000,
  parameter int LAST_INDEX   = 9,
  parameter int LOOP_INDEX   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [6:0]  addr_byte_in,
  input  logic        read_write,
  input  logic [7:0]  register_byte_in,
  input  logic [7:0]  data_byte_in,
  input  logic        continue_bit,
  input  logic        only_register,
  input  logic        sda_in,
  output logic [3:0]  state,
  output logic [9:0]  data_counter,
  output logic        scl,
  output logic        sda_oe,
  output logic [15:0] read_data,
  output logic [9:0]  read_index,
  output logic        read_valid,
  output logic        ack_error,
  output logic        busy
);

  localparam int DIV   = (CLK_DIV < 2) ? 2 : CLK_DIV;
  localparam int DLY   = (DELAY_CYCLES < 1) ? 1 : DELAY_CYCLES;
  localparam int DIV_W = $clog2(DIV);
  localparam int DLY_W = $clog2(DLY + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'(DLY - 1);

  typedef enum logic [3:0] {
    ST_IDLE            = 4'd0,
    ST_START           = 4'd1,
    ST_ADDRESS         = 4'd2,
    ST_WRITE_REGISTER  = 4'd3,
    ST_WRITE_DATA      = 4'd4,
    ST_READ            = 4'd5,
    ST_ACKNOWLEDGE     = 4'd6,
    ST_RECOGNITION_ACK = 4'd7,
    ST_STOP            = 4'd8,
    ST_DELAY           = 4'd9,
    ST_SEND_READ_ACK   = 4'd10
  } state_t;

  state_t            state_r;
  state_t            last_byte_r;
  logic [DIV_W-1:0]  div_cnt_r;
  logic [DLY_W-1:0]  dly_cnt_r;
  logic [1:0]        phase_r;
  logic [2:0]        bit_cnt_r;
  logic [1:0]        ack_cnt_r;
  logic [7:0]        tx_shift_r;
  logic [15:0]       rx_shift_r;
  logic              second_byte_r;
  logic              nack_r;
  logic              rw_r;
  logic [7:0]        reg_byte_r;
  logic              cont_r;
  logic [9:0]        block_start_r;
  logic [9:0]        data_counter_r;
  logic              scl_r;
  logic              sda_oe_r;
  logic [15:0]       read_data_r;
  logic [9:0]        read_index_r;
  logic              read_valid_r;
  logic              ack_error_r;
  logic              in_bit_s;
  logic              tick_s;

  // Descriptor index advance with wrap back into the polling loop
  function automatic logic [9:0] next_index(input logic [9:0] idx);
    if (idx == 10'(LAST_INDEX)) return 10'(LOOP_INDEX);
    else return idx + 10'd1;
  endfunction

  // States that run on the quarter-bit tick grid
  always_comb begin
    in_bit_s = 1'b0;
    case (state_r)
      ST_IDLE, ST_DELAY, ST_ACKNOWLEDGE: in_bit_s = 1'b0;
      default:                           in_bit_s = 1'b1;
    endcase
  end

  assign tick_s = in_bit_s && (div_cnt_r == DIV_LAST);

  // Quarter-bit divider, parked at zero outside bit-timed states
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_r <= '0;
    end else if (!in_bit_s || tick_s) begin
      div_cnt_r <= '0;
    end else begin
      div_cnt_r <= div_cnt_r + DIV_W'(1);
    end
  end

  // Transaction FSM; a tick with phase_r==1 starts SCL-high, phase_r==3 ends the bit
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= ST_IDLE;
      last_byte_r    <= ST_IDLE;
      dly_cnt_r      <= '0;
      phase_r        <= 2'd0;
      bit_cnt_r      <= 3'd0;
      ack_cnt_r      <= 2'd0;
      tx_shift_r     <= 8'd0;
      rx_shift_r     <= 16'd0;
      second_byte_r  <= 1'b0;
      nack_r         <= 1'b0;
      rw_r           <= 1'b0;
      reg_byte_r     <= 8'd0;
      cont_r         <= 1'b0;
      block_start_r  <= 10'd0;
      data_counter_r <= 10'd0;
      scl_r          <= 1'b1;
      sda_oe_r       <= 1'b0;
      read_data_r    <= 16'd0;
      read_index_r   <= 10'd0;
      read_valid_r   <= 1'b0;
      ack_error_r    <= 1'b0;
    end else begin
      read_valid_r <= 1'b0;
      ack_error_r  <= 1'b0;
      if (tick_s) phase_r <= phase_r + 2'd1;

      case (state_r)
        ST_IDLE: begin
          scl_r    <= 1'b1;
          sda_oe_r <= 1'b0;
          if (enable) begin
            state_r <= ST_START;
            phase_r <= 2'd0;
          end
        end

        ST_START: begin
          if (tick_s) begin
            case (phase_r)
              2'd1: begin
                sda_oe_r      <= 1'b1;
                tx_shift_r    <= {addr_byte_in, read_write};
                rw_r          <= read_write;
                reg_byte_r    <= register_byte_in;
                block_start_r <= data_counter_r;
              end
              2'd3: begin
                state_r   <= ST_ADDRESS;
                scl_r     <= 1'b0;
                sda_oe_r  <= ~tx_shift_r[7];
                bit_cnt_r <= 3'd0;
              end
              default: ;
            endcase
          end
        end

        ST_ADDRESS, ST_WRITE_REGISTER, ST_WRITE_DATA: begin
          if (tick_s) begin
            case (phase_r)
              2'd1: scl_r <= 1'b1;
              2'd3: begin
                scl_r <= 1'b0;
                if (bit_cnt_r == 3'd7) begin
                  state_r     <= ST_RECOGNITION_ACK;
                  last_byte_r <= state_r;
                  sda_oe_r    <= 1'b0;
                end else begin
                  tx_shift_r <= {tx_shift_r[6:0], 1'b0};
                  sda_oe_r   <= ~tx_shift_r[6];
                  bit_cnt_r  <= bit_cnt_r + 3'd1;
                end
              end
              default: ;
            endcase
          end
        end

        ST_RECOGNITION_ACK: begin
          if (tick_s) begin
            case (phase_r)
              2'd1: begin
                scl_r  <= 1'b1;
                nack_r <= sda_in;
              end
              2'd3: begin
                scl_r     <= 1'b0;
                bit_cnt_r <= 3'd0;
                if (nack_r) begin
                  // Whole block is retried from its first descriptor
                  ack_error_r    <= 1'b1;
                  data_counter_r <= block_start_r;
                  state_r        <= ST_STOP;
                  sda_oe_r       <= 1'b1;
                end else begin
                  case (last_byte_r)
                    ST_ADDRESS: begin
                      if (rw_r) begin
                        state_r       <= ST_READ;
                        sda_oe_r      <= 1'b0;
                        second_byte_r <= 1'b0;
                      end else begin
                        state_r    <= ST_WRITE_REGISTER;
                        tx_shift_r <= reg_byte_r;
                        sda_oe_r   <= ~reg_byte_r[7];
                      end
                    end
                    ST_WRITE_REGISTER: begin
                      if (only_register) begin
                        state_r        <= ST_STOP;
                        sda_oe_r       <= 1'b1;
                        data_counter_r <= next_index(data_counter_r);
                      end else begin
                        state_r    <= ST_WRITE_DATA;
                        tx_shift_r <= data_byte_in;
                        cont_r     <= continue_bit;
                        sda_oe_r   <= ~data_byte_in[7];
                      end
                    end
                    ST_WRITE_DATA: begin
                      data_counter_r <= next_index(data_counter_r);
                      if (cont_r) begin
                        state_r   <= ST_ACKNOWLEDGE;
                        sda_oe_r  <= 1'b0;
                        ack_cnt_r <= 2'd0;
                      end else begin
                        state_r  <= ST_STOP;
                        sda_oe_r <= 1'b1;
                      end
                    end
                    default: begin
                      state_r  <= ST_STOP;
                      sda_oe_r <= 1'b1;
                    end
                  endcase
                end
              end
              default: ;
            endcase
          end
        end

        ST_ACKNOWLEDGE: begin
          // Idle gap lets the upstream descriptor follow the new data_counter
          scl_r <= 1'b0;
          if (ack_cnt_r == 2'd3) begin
            state_r    <= ST_WRITE_DATA;
            tx_shift_r <= data_byte_in;
            cont_r     <= continue_bit;
            sda_oe_r   <= ~data_byte_in[7];
            bit_cnt_r  <= 3'd0;
            phase_r    <= 2'd0;
          end else begin
            ack_cnt_r <= ack_cnt_r + 2'd1;
          end
        end

        ST_READ: begin
          if (tick_s) begin
            case (phase_r)
              2'd1: begin
                scl_r      <= 1'b1;
                rx_shift_r <= {rx_shift_r[14:0], sda_in};
              end
              2'd3: begin
                scl_r <= 1'b0;
                if (bit_cnt_r == 3'd7) begin
                  state_r  <= ST_SEND_READ_ACK;
                  sda_oe_r <= ~second_byte_r;
                end else begin
                  sda_oe_r  <= 1'b0;
                  bit_cnt_r <= bit_cnt_r + 3'd1;
                end
              end
              default: ;
            endcase
          end
        end

        ST_SEND_READ_ACK: begin
          if (tick_s) begin
            case (phase_r)
              2'd1: scl_r <= 1'b1;
              2'd3: begin
                scl_r     <= 1'b0;
                bit_cnt_r <= 3'd0;
                if (!second_byte_r) begin
                  state_r       <= ST_READ;
                  second_byte_r <= 1'b1;
                  sda_oe_r      <= 1'b0;
                end else begin
                  state_r        <= ST_STOP;
                  sda_oe_r       <= 1'b1;
                  read_data_r    <= rx_shift_r;
                  read_index_r   <= data_counter_r;
                  read_valid_r   <= 1'b1;
                  data_counter_r <= next_index(data_counter_r);
                end
              end
              default: ;
            endcase
          end
        end

        ST_STOP: begin
          if (tick_s) begin
            case (phase_r)
              2'd1: scl_r    <= 1'b1;
              2'd2: sda_oe_r <= 1'b0;
              2'd3: begin
                state_r   <= ST_DELAY;
                dly_cnt_r <= '0;
              end
              default: ;
            endcase
          end
        end

        ST_DELAY: begin
          scl_r    <= 1'b1;
          sda_oe_r <= 1'b0;
          if (dly_cnt_r == DLY_LAST) begin
            dly_cnt_r <= '0;
            phase_r   <= 2'd0;
            if (enable) state_r <= ST_START;
            else state_r <= ST_IDLE;
          end else begin
            dly_cnt_r <= dly_cnt_r + DLY_W'(1);
          end
        end

        default: begin
          state_r  <= ST_IDLE;
          scl_r    <= 1'b1;
          sda_oe_r <= 1'b0;
        end
      endcase
    end
  end

  assign state        = state_r;
  assign data_counter = data_counter_r;
  assign scl          = scl_r;
  assign sda_oe       = sda_oe_r;
  assign read_data    = read_data_r;
  assign read_index   = read_index_r;
  assign read_valid   = read_valid_r;
  assign ack_error    = ack_error_r;
  assign busy         = (state_r != ST_IDLE);

endmodule

// File: tb/tb_ads1115_i2c_engine.sv
// Directed bench: descriptor table stands in for the upstream stage, a bus
// monitor/slave decodes START/bytes/ACKs/STOP and answers reads.
module tb_ads1115_i2c_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [6:0]  d_addr;
  logic        d_rw;
  logic [7:0]  d_reg;
  logic [7:0]  d_data;
  logic        d_cont;
  logic        d_only;
  logic        sda_in;
  logic [3:0]  state;
  logic [9:0]  data_counter;
  logic        scl;
  logic        sda_oe;
  logic [15:0] read_data;
  logic [9:0]  read_index;
  logic        read_valid;
  logic        ack_error;
  logic        busy;
  logic        slave_pull = 1'b0;

  int checks = 0;
  int failures = 0;
  int nack_byte = -1;

  // monitor state (written only by the monitor process)
  int          ev[$];
  int          acks[$];
  int          ack_entries = 0;
  int          wd_entries = 0;
  int          rv_cycles = 0;
  int          ae_cycles = 0;
  int          both_seen = 0;
  logic [15:0] rv_data = 16'd0;
  logic [9:0]  rv_index = 10'd0;
  logic [3:0]  rv_state = 4'd0;

  int exp_q[$];
  int ev_base = 0;
  int ack_base = 0;

  always #5 clk = ~clk;

  assign sda_in = !(sda_oe || slave_pull);

  always_comb begin
    d_addr = 7'h48; d_rw = 1'b0; d_reg = 8'h02; d_data = 8'h00; d_cont = 1'b0; d_only = 1'b1;
    case (data_counter)
      10'd0: begin d_reg = 8'h01; d_data = 8'hC1; d_cont = 1'b1; d_only = 1'b0; end
      10'd1: begin d_reg = 8'h01; d_data = 8'h80; d_only = 1'b0; end
      10'd6: d_reg = 8'h01;
      10'd7, 10'd8: d_reg = 8'h00;
      10'd9: begin d_rw = 1'b1; d_reg = 8'h00; d_only = 1'b0; end
      default: ;
    endcase
  end

  ads1115_i2c_engine #(.CLK_DIV(4), .DELAY_CYCLES(20)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .addr_byte_in(d_addr), .read_write(d_rw), .register_byte_in(d_reg),
    .data_byte_in(d_data), .continue_bit(d_cont), .only_register(d_only),
    .sda_in(sda_in), .state(state), .data_counter(data_counter),
    .scl(scl), .sda_oe(sda_oe), .read_data(read_data), .read_index(read_index),
    .read_valid(read_valid), .ack_error(ack_error), .busy(busy)
  );

  // Bus monitor and ADS1115-like slave, sampled on the falling clock edge
  initial begin
    logic       prev_scl = 1'b1;
    logic       prev_sda = 1'b1;
    logic       line;
    logic [7:0] shreg = 8'd0;
    logic [7:0] rb;
    logic [3:0] prev_state = 4'd0;
    int         bcnt = 0;
    int         byte_no = 0;
    logic       is_read = 1'b0;
    forever begin
      @(negedge clk);
      line = !(sda_oe || slave_pull);
      if (prev_scl && scl && prev_sda && !line) begin
        ev.push_back(256); bcnt = 0; byte_no = 0; is_read = 1'b0;
      end else if (prev_scl && scl && !prev_sda && line) begin
        ev.push_back(257);
      end else if (!prev_scl && scl) begin
        if (bcnt < 8) begin
          shreg = {shreg[6:0], line};
          if (bcnt == 7) begin
            ev.push_back(int'(shreg));
            if (byte_no == 0) is_read = shreg[0];
          end
        end else begin
          acks.push_back(int'(line));
        end
        bcnt++;
      end else if (prev_scl && !scl) begin
        if (bcnt == 9) begin bcnt = 0; byte_no++; end
        rb = (byte_no == 1) ? 8'h12 : 8'h34;
        if (bcnt == 8) slave_pull = (!is_read || byte_no == 0) && (byte_no != nack_byte);
        else if (is_read && (byte_no == 1 || byte_no == 2)) slave_pull = !rb[7 - bcnt];
        else slave_pull = 1'b0;
      end
      prev_scl = scl;
      prev_sda = !(sda_oe || slave_pull);
      if (state == 4'd6 && prev_state != 4'd6) ack_entries++;
      if (state == 4'd4 && prev_state != 4'd4) wd_entries++;
      prev_state = state;
      if (read_valid) begin
        rv_cycles++; rv_data = read_data; rv_index = read_index; rv_state = state;
      end
      if (ack_error) ae_cycles++;
      if (read_valid && ack_error) both_seen++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_log(input string tag);
    int n;
    chk({tag, "_len"}, ev.size() - ev_base, exp_q.size());
    n = ev.size() - ev_base;
    if (n > exp_q.size()) n = exp_q.size();
    for (int i = 0; i < n; i++) chk({tag, "_ev"}, ev[ev_base + i], exp_q[i]);
  endtask

  task automatic wait_for(input logic [3:0] st, input logic [9:0] dc, input int budget, input string tag);
    int n = 0;
    while (!(state == st && data_counter == dc) && n < budget) begin
      @(negedge clk); n++;
    end
    chk({tag, "_reached"}, (state == st && data_counter == dc), 1);
  endtask

  initial begin
    int ae0, ack0, wd0, rv0;
    // reset
    repeat (3) @(negedge clk);
    chk("rst_state", state, 4'd0);
    chk("rst_dc", data_counter, 10'd0);
    chk("rst_scl", scl, 1'b1);
    chk("rst_sda_oe", sda_oe, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_read_valid", read_valid, 1'b0);

    // config write, indices 0-1
    ack0 = ack_entries; ev_base = ev.size(); ack_base = acks.size();
    rst = 1'b0; enable = 1'b1;
    wait_for(4'd9, 10'd2, 3000, "cfg");
    exp_q = {256, 8'h90, 8'h01, 8'hC1, 8'h80, 257};
    check_log("cfg");
    chk("cfg_ack_state_entries", ack_entries - ack0, 1);
    chk("cfg_slave_acks", acks.size() - ack_base, 4);

    // pointer-only write at index 6
    wait_for(4'd9, 10'd6, 5000, "to_idx6");
    ev_base = ev.size(); wd0 = wd_entries;
    wait_for(4'd9, 10'd7, 3000, "ptr");
    exp_q = {256, 8'h90, 8'h01, 257};
    check_log("ptr");
    chk("ptr_no_write_data", wd_entries - wd0, 0);

    // conversion read at index 9, wraps to 8
    wait_for(4'd9, 10'd9, 5000, "to_idx9");
    ev_base = ev.size(); ack_base = acks.size(); rv0 = rv_cycles;
    wait_for(4'd9, 10'd8, 3000, "rd");
    exp_q = {256, 8'h91, 8'h12, 8'h34, 257};
    check_log("rd");
    chk("rd_addr_ack", acks[ack_base], 0);
    chk("rd_master_ack", acks[ack_base + 1], 0);
    chk("rd_master_nack", acks[ack_base + 2], 1);
    chk("rd_valid_cycles", rv_cycles - rv0, 1);
    chk("rd_data", rv_data, 16'h1234);
    chk("rd_index", rv_index, 10'd9);
    chk("rd_valid_at_stop", rv_state, 4'd8);

    // address NACK, then data-byte NACK at index 1, then clean retry
    @(negedge clk); rst = 1'b1; repeat (3) @(negedge clk);
    nack_byte = 0; ev_base = ev.size(); ae0 = ae_cycles;
    rst = 1'b0;
    wait_for(4'd9, 10'd0, 3000, "anack");
    exp_q = {256, 8'h90, 257};
    check_log("anack");
    chk("anack_ack_error", ae_cycles - ae0, 1);
    nack_byte = 3; ev_base = ev.size(); ae0 = ae_cycles; ack0 = ack_entries;
    wait_for(4'd1, 10'd0, 200, "dnack_start");
    wait_for(4'd9, 10'd0, 3000, "dnack");
    exp_q = {256, 8'h90, 8'h01, 8'hC1, 8'h80, 257};
    check_log("dnack");
    chk("dnack_ack_error", ae_cycles - ae0, 1);
    chk("dnack_passed_idx1", ack_entries - ack0, 1);
    nack_byte = -1; ev_base = ev.size();
    wait_for(4'd1, 10'd0, 200, "retry_start");
    wait_for(4'd9, 10'd2, 3000, "retry");
    check_log("retry");
    chk("no_coincident_pulses", both_seen, 0);

    // reset during WRITE_DATA bit 3
    rst = 1'b1; repeat (3) @(negedge clk); rst = 1'b0;
    wait_for(4'd6, 10'd1, 3000, "mid_ack");
    wait_for(4'd4, 10'd1, 20, "mid_wd");
    repeat (48) @(negedge clk);
    chk("mid_state", state, 4'd4);
    chk("mid_scl_low", scl, 1'b0);
    chk("mid_busy", busy, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_scl", scl, 1'b1);
    chk("mid_rst_sda_oe", sda_oe, 1'b0);
    chk("mid_rst_state", state, 4'd0);
    chk("mid_rst_dc", data_counter, 10'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
